// File: rtl/risc_pkg.sv
// Shared constants and types for the fetch stage of the small RISC pipeline.
package risc_pkg;

    localparam int PC_WIDTH    = 8;
    localparam int INSTR_WIDTH = 16;

    localparam logic [PC_WIDTH-1:0]    RESET_PC  = 8'h00;
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = '0;

    // RUN: normal fetch. REFILL: waiting for the branch target to arrive.
    typedef enum logic {
        RUN    = 1'b0,
        REFILL = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/ifid_fetch_unit_pc_register.sv
// Program counter: the PC flop, its +1 incrementer and the next-PC select.
// A redirect beats a stall, and a stall beats a memory miss.
module pc_register #(
    parameter int PC_WIDTH = risc_pkg::PC_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                branch_pc_src,
    input  logic [PC_WIDTH-1:0] branch_addr,
    input  logic                pc_write,
    input  logic                instr_ready,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus1
);
    import risc_pkg::*;

    logic [PC_WIDTH-1:0] next_pc;

    // The incrementer wraps silently at the top of the address space.
    assign pc_plus1 = pc + PC_WIDTH'(1);

    // Pick the next PC: take the redirect first, otherwise advance only when not stalled and the fetch succeeded.
    always_comb begin
        next_pc = pc;
        if (branch_pc_src) begin
            next_pc = branch_addr;
        end else if (pc_write && instr_ready) begin
            next_pc = pc_plus1;
        end
    end

    // PC flop with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= PC_WIDTH'(RESET_PC);
        end else begin
            pc <= next_pc;
        end
    end

endmodule

// File: rtl/ifid_fetch_unit.sv
// Instruction fetch stage: PC, IF/ID pipeline register, refill FSM and a redirect counter.
module ifid_fetch_unit #(
    parameter int PC_WIDTH    = risc_pkg::PC_WIDTH,
    parameter int INSTR_WIDTH = risc_pkg::INSTR_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   branchPcSrc,
    input  logic [PC_WIDTH-1:0]    branchAddr,
    input  logic                   IFID_flush,
    input  logic                   PCWrite,
    input  logic                   IFIDWrite,
    input  logic [INSTR_WIDTH-1:0] instrIn,
    input  logic                   instrReady,
    output logic [PC_WIDTH-1:0]    instrAddr,
    output logic [INSTR_WIDTH-1:0] IFID_instr,
    output logic [PC_WIDTH-1:0]    IFID_pcPlus1,
    output logic                   IFID_valid,
    output logic [7:0]             flushCount
);
    import risc_pkg::*;

    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_plus1;
    logic [PC_WIDTH-1:0] refill_target;
    logic                accept_fetch;
    fetch_state_t        state;
    fetch_state_t        next_state;

    pc_register #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc_register (
        .clk           (clk),
        .reset         (reset),
        .branch_pc_src (branchPcSrc),
        .branch_addr   (branchAddr),
        .pc_write      (PCWrite),
        .instr_ready   (instrReady),
        .pc            (pc),
        .pc_plus1      (pc_plus1)
    );

    assign instrAddr = pc;

    // Refill FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Any redirect (re)enters REFILL; leave once the target has actually been fetched.
    always_comb begin
        next_state = state;
        case (state)
            RUN: begin
                if (branchPcSrc) begin
                    next_state = REFILL;
                end
            end
            REFILL: begin
                if (branchPcSrc) begin
                    next_state = REFILL;
                end else if (instrReady && PCWrite) begin
                    next_state = RUN;
                end
            end
            default: next_state = RUN;
        endcase
    end

    // While refilling, only an instruction from the latched target address may enter IF/ID.
    always_comb begin
        accept_fetch = instrReady;
        if ((state == REFILL) && (pc != refill_target)) begin
            accept_fetch = 1'b0;
        end
    end

    // Remember the most recent redirect target for the refill address check.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            refill_target <= PC_WIDTH'(RESET_PC);
        end else if (branchPcSrc) begin
            refill_target <= branchAddr;
        end
    end

    // Count taken redirects, sticking at the maximum value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flushCount <= 8'h00;
        end else if (branchPcSrc && (flushCount != 8'hFF)) begin
            flushCount <= flushCount + 8'h01;
        end
    end

    // IF/ID register: flush beats hold, hold beats a bubble, and a good fetch loads the instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            IFID_instr   <= INSTR_WIDTH'(NOP_INSTR);
            IFID_pcPlus1 <= '0;
            IFID_valid   <= 1'b0;
        end else if (IFID_flush) begin
            IFID_instr <= INSTR_WIDTH'(NOP_INSTR);
            IFID_valid <= 1'b0;
        end else if (!IFIDWrite) begin
            IFID_instr   <= IFID_instr;
            IFID_pcPlus1 <= IFID_pcPlus1;
            IFID_valid   <= IFID_valid;
        end else if (accept_fetch) begin
            IFID_instr   <= instrIn;
            IFID_pcPlus1 <= pc_plus1;
            IFID_valid   <= 1'b1;
        end else begin
            IFID_instr <= INSTR_WIDTH'(NOP_INSTR);
            IFID_valid <= 1'b0;
        end
    end

endmodule
